// File: rtl/gc_req_queue_if.sv
// Host request / controller handshake bundle for gc_req_queue.
// slave is the queue's view; master is the host-plus-controller side.
interface gc_req_queue_if #(
    parameter int AW = 10,
    parameter int DW = 64
);
    logic          host_valid;
    logic          host_ready;
    logic          host_wr;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_in;
    logic          mem_busy;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  host_valid, host_wr, host_addr, host_wdata, mem_busy, mem_rd,
        output host_ready, host_rvalid, host_rdata,
               mem_we, mem_re, mem_waddr, mem_raddr, mem_in
    );

    modport master (
        output host_valid, host_wr, host_addr, host_wdata, mem_busy, mem_rd,
        input  host_ready, host_rvalid, host_rdata,
               mem_we, mem_re, mem_waddr, mem_raddr, mem_in
    );
endinterface

// File: rtl/gc_req_queue.sv
// In-order host request FIFO feeding the GC-DRAM controller, with read return and stall counter.
// Optional GC_REQQ_BYPASS_EN: an empty, idle queue forwards the host request to mem_* in the same cycle.
module gc_req_queue #(
    parameter int DEPTH  = 4,
    parameter int AW     = 10,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    gc_req_queue_if.slave            bus,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic [15:0]              stall_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [15:0]       stall_q, stall_d;

    logic              fifo_wr_q   [DEPTH];
    logic [AW-1:0]     fifo_addr_q [DEPTH];
    logic [DW-1:0]     fifo_data_q [DEPTH];

    logic              empty, full, push, pop, byp;
    logic              mem_we, mem_re;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_in;
    logic [DW-1:0]     push_wdata;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);

    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_in   = '0;
        byp      = 1'b0;
        if (!empty) begin
            mem_addr = fifo_addr_q[rptr_q[IW-1:0]];
            mem_in   = fifo_data_q[rptr_q[IW-1:0]];
            if (!bus.mem_busy) begin
                mem_we = fifo_wr_q[rptr_q[IW-1:0]];
                mem_re = !fifo_wr_q[rptr_q[IW-1:0]];
            end
        end
`ifdef GC_REQQ_BYPASS_EN
        // rst gating keeps mem_* at zero while reset is held
        else if (rst && !bus.mem_busy && bus.host_valid) begin
            byp      = 1'b1;
            mem_addr = bus.host_addr;
            mem_in   = bus.host_wr ? bus.host_wdata : '0;
            mem_we   = bus.host_wr;
            mem_re   = !bus.host_wr;
        end
`endif
    end

    assign pop        = !empty && !bus.mem_busy;
    assign push       = bus.host_valid && !full && !byp;
    assign push_wdata = bus.host_wr ? bus.host_wdata : '0;

    always_comb begin
        wptr_d = wptr_q + {{(PW-1){1'b0}}, push};
        rptr_d = rptr_q + {{(PW-1){1'b0}}, pop};

        tag_d    = '0;
        tag_d[0] = mem_re;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        rvalid_d = tag_q[RD_LAT-1];
        rdata_d  = tag_q[RD_LAT-1] ? bus.mem_rd : rdata_q;

        stall_d = stall_q;
        if (bus.mem_busy && !empty && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            tag_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            stall_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            tag_q    <= tag_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            stall_q  <= stall_d;
        end
    end

    // Entry storage needs no reset: it is only observed when non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr_q[wptr_q[IW-1:0]]   <= bus.host_wr;
            fifo_addr_q[wptr_q[IW-1:0]] <= bus.host_addr;
            fifo_data_q[wptr_q[IW-1:0]] <= push_wdata;
        end
    end

    assign bus.host_ready  = !full;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = rdata_q;
    assign bus.mem_we      = mem_we;
    assign bus.mem_re      = mem_re;
    assign bus.mem_waddr   = mem_addr;
    assign bus.mem_raddr   = mem_addr;
    assign bus.mem_in      = mem_in;
    assign q_level         = wptr_q - rptr_q;
    assign stall_cnt       = stall_q;

endmodule

// File: doc/gc_req_queue.md
# gc_req_queue

Host-side request queue that sits directly upstream of the GC-DRAM top-level controller. It buffers host read and write requests in an in-order FIFO and issues them to the controller only in cycles where the controller is not busy (refresh or ongoing access). It returns read data to the host with a valid strobe and counts stall cycles for performance monitoring.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- AW, 10: address width.
- DW, 64: data width.
- RD_LAT, 1: cycles from the read-acceptance edge to valid `mem_rd`; legal range 1..4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- host_valid  in  1  host request present.
- host_ready  out  1  queue can accept; equals !full.
- host_wr  in  1  1 = write, 0 = read.
- host_addr  in  AW  request address.
- host_wdata  in  DW  write data; ignored for reads.
- host_rvalid  out  1  one-cycle strobe; `host_rdata` is valid.
- host_rdata  out  DW  returned read data.
- mem_we  out  1  write strobe to the controller.
- mem_re  out  1  read strobe to the controller.
- mem_waddr  out  AW  write address.
- mem_raddr  out  AW  read address.
- mem_in  out  DW  write data.
- mem_busy  in  1  controller busy; no request is accepted while it is high.
- mem_rd  in  DW  controller read data.
- q_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- stall_cnt  out  16  saturating count of cycles with `mem_busy`=1 and the queue non-empty.

## Operation
- **Push.** A request enters the tail at an edge where `host_valid && host_ready`.
  - Stored entry: {wr, addr, wdata}; `wdata` is stored as 0 for reads.
- **Issue.** Issue is combinational from the head entry.
  - `mem_we` = !empty && !mem_busy && head.wr.
  - `mem_re` = !empty && !mem_busy && !head.wr.
  - The head address drives both `mem_waddr` and `mem_raddr`. `mem_in` = head.wdata.
  - When the queue is empty, all `mem_*` outputs are 0.
- **Pop.** The head is popped at every edge where `mem_we | mem_re` is high.
  - Ordering is strictly in order; one request issues per cycle.
  - A read after a write to the same address is therefore always correct.
- **Simultaneous push and pop.** Both happen; `q_level` is unchanged.
  - Full plus pop: `host_ready` is still 0 that cycle. There is no pop-through.
- **Read return.** An RD_LAT-deep tag shift register marks accepted reads.
  - At the edge where the tag exits, `mem_rd` is captured into `host_rdata`.
  - `host_rvalid` is high for the following cycle.
  - `host_rdata` holds its value until the next capture.
  - Back-to-back reads produce back-to-back `host_rvalid` pulses.
- **stall_cnt.** Increments each edge with `mem_busy && !empty`. It saturates at 16'hFFFF and clears only on reset.
- **Pointers.** Read and write pointers are $clog2(DEPTH)+1 bits wide. The MSB distinguishes full from empty, and pointers wrap modulo 2·DEPTH.
- **Reset (rst=0, asynchronous, any time).** Reset clears the FIFO pointers, the tag pipe and `stall_cnt`.
  - Outputs during and after reset: `host_ready`=1, `host_rvalid`=0, `host_rdata`=0, `mem_we`=0, `mem_re`=0, `mem_*` addr/data=0, `q_level`=0, `stall_cnt`=0.
  - Reads in flight are dropped and no `host_rvalid` is generated for them.
  - Deassertion is synchronised externally.

## Timing
- Push to earliest issue is 1 cycle: the request pushed at edge E0 is driven on `mem_*` in the cycle after E0 and accepted at E1 if `mem_busy`=0.
- Each cycle of `mem_busy`=1 adds one cycle of delay; `mem_*` strobes are 0 for the whole busy window.
- Read latency, host push to `host_rvalid`: RD_LAT+2 cycles without bypass and no stall.
- `host_ready` depends only on the registered occupancy. It has no combinational path from `host_valid` or `mem_busy`.
- Sustained throughput is 1 request per cycle while `mem_busy`=0.

## Configuration
- **`GC_REQQ_BYPASS_EN` defined.** When the queue is empty, `mem_busy`=0 and `host_valid`=1, the host request drives `mem_*` combinationally in the same cycle and is not written into the FIFO.
  - This saves 1 cycle of latency.
  - It adds a combinational path from `host_*` to `mem_*`.
- **`GC_REQQ_BYPASS_EN` undefined.** Every request passes through the FIFO, and `mem_*` are driven only from the head entry.

## Test plan
- **Basic write/read.** Write 0x3FF ← 64'hDEAD_BEEF_0123_4567, then read 0x3FF with `mem_busy`=0 → one `mem_we` then one `mem_re`; `host_rvalid` pulses once with `host_rdata`=64'hDEAD_BEEF_0123_4567.
- **Fill, stall, drain.** Hold `mem_busy`=1 and push 4 requests → `q_level`=4, `host_ready`=0, `mem_we`/`mem_re`=0, `stall_cnt` increments every cycle. Release busy → 4 consecutive issues in push order, then `q_level`=0.
- **Push and pop when full.** With the queue full and `mem_busy`=0, hold `host_valid`=1 → no push in the full cycle; `q_level` goes 4→3, then stays at 3 while push and pop coincide.
- **Busy mid-stream.** 8 back-to-back reads with `mem_busy` pulsed for 3 cycles in the middle → exactly 8 `host_rvalid` pulses in order, with a 3-cycle gap.
- **Reset mid-operation.** Drop `rst` with 3 entries queued and a read in flight → all outputs reach reset values immediately, no `host_rvalid` appears afterwards, and `stall_cnt`=0.
- **Bypass (with `GC_REQQ_BYPASS_EN`).** Empty queue, `mem_busy`=0, read pushed at edge E0 → `mem_re` is high in the cycle before E0 and `q_level` stays 0. Without the macro, `mem_re` is high in the cycle after E0.
